// File: rtl/rcon_seq.sv
// Sequential AES round-constant generator: streams Rcon[1..N] over valid/ready,
// advancing by GF(2^8) xtime on each accepted transfer.
module rcon_seq #(
    parameter int              RC_W  = 8,
    parameter logic [RC_W-1:0] POLY  = 8'h1B,
    parameter int              IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       key_len,
    input  logic             abort,
    input  logic             rc_ready,
    output logic             rc_valid,
    output logic [RC_W-1:0]  rc_out,
    output logic [IDX_W-1:0] rc_idx,
    output logic             rc_last,
    output logic             busy,
    output logic             done,
    output logic             len_err
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] n_reg, n_nx, n_len, idx_nx;
    logic [RC_W-1:0]  rc_nx;
    logic             valid_nx, done_nx, len_err_nx;

    function automatic logic [RC_W-1:0] xtime(input logic [RC_W-1:0] x);
        return {x[RC_W-2:0], 1'b0} ^ (x[RC_W-1] ? POLY : '0);
    endfunction

    always_comb begin
        n_len = '0;
        case (key_len)
            2'b00:   n_len = IDX_W'(10);
            2'b01:   n_len = IDX_W'(8);
            2'b10:   n_len = IDX_W'(7);
            default: n_len = '0;
        endcase
    end

    // NOTE: every next-value gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_nx   = state;
        n_nx       = n_reg;
        rc_nx      = rc_out;
        idx_nx     = rc_idx;
        valid_nx   = rc_valid;
        done_nx    = 1'b0;
        len_err_nx = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (key_len == 2'b11) begin
                        len_err_nx = 1'b1;
                    end else begin
                        state_nx = RUN;
                        n_nx     = n_len;
                        rc_nx    = RC_W'(1);
                        idx_nx   = IDX_W'(1);
                        valid_nx = 1'b1;
                    end
                end
            end
            RUN: begin
                // abort outranks a pending transfer
                if (abort) begin
                    state_nx = IDLE;
                    valid_nx = 1'b0;
                    idx_nx   = '0;
                end else if (rc_valid && rc_ready) begin
                    if (rc_idx == n_reg) begin
                        state_nx = IDLE;
                        valid_nx = 1'b0;
                        done_nx  = 1'b1;
                    end else begin
                        rc_nx  = xtime(rc_out);
                        idx_nx = rc_idx + IDX_W'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            n_reg    <= '0;
            rc_out   <= '0;
            rc_idx   <= '0;
            rc_valid <= 1'b0;
            done     <= 1'b0;
            len_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            n_reg    <= n_nx;
            rc_out   <= rc_nx;
            rc_idx   <= idx_nx;
            rc_valid <= valid_nx;
            done     <= done_nx;
            len_err  <= len_err_nx;
        end
    end

    assign busy    = (state == RUN);
    assign rc_last = rc_valid && (rc_idx == n_reg);

endmodule

// File: tb/tb_rcon_seq.sv
// Self-checking bench for rcon_seq: table-driven sequences checked through a
// scoreboard of expected round constants, plus abort, len_err and reset cases.
module tb_rcon_seq;

    logic       clk = 1'b0;
    logic       rst, start, abort, rc_ready;
    logic [1:0] key_len;
    logic       rc_valid, rc_last, busy, done, len_err;
    logic [7:0] rc_out;
    logic [3:0] rc_idx;

    rcon_seq dut (
        .clk(clk), .rst(rst), .start(start), .key_len(key_len), .abort(abort),
        .rc_ready(rc_ready), .rc_valid(rc_valid), .rc_out(rc_out), .rc_idx(rc_idx),
        .rc_last(rc_last), .busy(busy), .done(done), .len_err(len_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rc;
        logic [3:0] idx;
        logic       last;
    } exp_t;

    typedef struct {
        logic [1:0] kl;
        int         stall_at;
        int         stall_n;
        bit         poke;
        logic [7:0] last_rc;
    } vec_t;

    exp_t       sb[$];
    vec_t       vecs[4];
    logic [7:0] rcon_tab[10];
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: condition not reached (t=%0t)", name, $time);
    endtask

    // Called at a negedge; leaves start high across one posedge.
    task automatic start_seq(input logic [1:0] kl, input bit with_abort);
        int   n;
        exp_t e;
        n = (kl == 2'b00) ? 10 : (kl == 2'b01) ? 8 : 7;
        start = 1'b1; key_len = kl; abort = with_abort; rc_ready = 1'b1;
        for (int i = 1; i <= n; i++) begin
            e.rc = rcon_tab[i-1]; e.idx = 4'(i); e.last = (i == n);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic drain(input int stall_at, input int stall_n, input bit poke);
        int   cyc = 0;
        int   stall_left = stall_n;
        bit   seen_done = 1'b0;
        exp_t e;
        while ((sb.size() != 0 || !seen_done) && cyc < 60) begin
            @(negedge clk);
            cyc++;
            start = poke && (sb.size() != 0);
            if (poke) key_len = 2'b10;
            if (rc_valid) begin
                if (sb.size() == 0) begin
                    fail("spurious_valid");
                end else begin
                    e = sb[0];
                    check("rc_out", rc_out, e.rc);
                    check("rc_idx", rc_idx, e.idx);
                    check("rc_last", rc_last, e.last);
                    check("busy_run", busy, 1);
                    check("done_early", done, 0);
                    if (stall_left > 0 && rc_idx == 4'(stall_at)) begin
                        rc_ready = 1'b0;
                        stall_left--;
                    end else begin
                        rc_ready = 1'b1;
                        void'(sb.pop_front());
                    end
                end
            end else if (done) begin
                check("done_q_empty", sb.size(), 0);
                check("busy_done", busy, 0);
                seen_done = 1'b1;
            end
        end
        start = 1'b0;
        if (!(sb.size() == 0 && seen_done)) fail("drain_timeout");
        @(negedge clk);
        check("done_pulse_width", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        int cyc;
        rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
        vecs[0] = '{kl: 2'b00, stall_at: 0, stall_n: 0, poke: 1'b0, last_rc: 8'h36};
        vecs[1] = '{kl: 2'b01, stall_at: 0, stall_n: 0, poke: 1'b0, last_rc: 8'h80};
        vecs[2] = '{kl: 2'b10, stall_at: 0, stall_n: 0, poke: 1'b0, last_rc: 8'h40};
        vecs[3] = '{kl: 2'b00, stall_at: 4, stall_n: 3, poke: 1'b1, last_rc: 8'h36};

        rst = 1'b1; start = 1'b0; key_len = 2'b00; abort = 1'b0; rc_ready = 1'b0;
        #12;
        check("rst_valid", rc_valid, 0);
        check("rst_out", rc_out, 0);
        check("rst_idx", rc_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_len_err", len_err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            start_seq(vecs[v].kl, 1'b0);
            drain(vecs[v].stall_at, vecs[v].stall_n, vecs[v].poke);
            check("rc_out_held_idle", rc_out, vecs[v].last_rc);
        end

        // abort in IDLE has no effect
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_valid", rc_valid, 0);
        check("idle_abort_out", rc_out, 8'h36);

        // abort mid-run at idx 5
        start_seq(2'b00, 1'b0);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (rc_idx != 4'd5 && cyc < 20);
        if (rc_idx != 4'd5) fail("abort_wait_idx5");
        check("abort_pre_rc", rc_out, 8'h10);
        abort = 1'b1; rc_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_valid", rc_valid, 0);
        check("abort_idx", rc_idx, 0);
        check("abort_busy", busy, 0);
        check("abort_no_done", done, 0);
        @(negedge clk);
        check("abort_no_done_late", done, 0);
        sb.delete();

        // restart, with abort in the same IDLE cycle as start (start wins)
        start_seq(2'b00, 1'b1);
        drain(0, 0, 1'b0);

        // illegal key length
        start = 1'b1; key_len = 2'b11;
        @(negedge clk);
        start = 1'b0;
        check("len_err_pulse", len_err, 1);
        check("len_err_valid", rc_valid, 0);
        check("len_err_busy", busy, 0);
        @(negedge clk);
        check("len_err_width", len_err, 0);
        check("len_err_still_idle", rc_valid, 0);

        // asynchronous reset mid-run
        start_seq(2'b01, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", rc_valid, 0);
        check("arst_out", rc_out, 0);
        check("arst_idx", rc_idx, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        start_seq(2'b10, 1'b0);
        drain(0, 0, 1'b0);
        check("post_rst_last", rc_out, 8'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
